// File: rtl/fact_sequencer.sv
// Control sequencer for the factorial datapath: reads n from RAM, loops multiply/decrement,
// writes n! back and reports range or overflow errors through a start/busy/done handshake.
module fact_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              counter_load,
  output logic              counter_dec,
  output logic              acc_init,
  output logic              acc_mul,
  input  logic [CNT_W-1:0]  counter_val,
  input  logic              mul_ovf,
  output logic [2:0]        state_out
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCheck = 3'd2,
    StMul   = 3'd3,
    StWrite = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic              err_q;
  logic              range_err;

  // Operand bits above the counter width mean n cannot be represented.
  assign range_err = (mem_rdata >> CNT_W) != '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            err_q   <= 1'b0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (range_err) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (counter_val <= CntOne) state_q <= StWrite;
          else                       state_q <= StMul;
        end
        StMul: begin
          if (mul_ovf) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StCheck;
          end
        end
        StWrite: state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy         = 1'b1;
    done         = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    counter_load = 1'b0;
    counter_dec  = 1'b0;
    acc_init     = 1'b0;
    acc_mul      = 1'b0;
    case (state_q)
      StIdle: busy = 1'b0;
      StLoad: begin
        mem_addr     = src_q;
        counter_load = 1'b1;
        acc_init     = 1'b1;
      end
      StCheck: ;
      StMul: begin
        acc_mul     = 1'b1;
        counter_dec = 1'b1;
      end
      StWrite: begin
        mem_addr = dst_q;
        mem_we   = 1'b1;
      end
      StDone:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign err       = err_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_fact_sequencer.sv
// Bench for fact_sequencer: behavioural RAM/datapath around the DUT, factorial reference model
// feeding a scoreboard queue that a negedge monitor drains on every done pulse.
module tb_fact_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  src_addr = '0;
  logic [3:0]  dst_addr = '0;
  logic        busy, done, err, mem_we, mul_ovf;
  logic [3:0]  mem_addr, counter_val;
  logic [15:0] mem_rdata;
  logic        counter_load, counter_dec, acc_init, acc_mul;
  logic [2:0]  state_out;

  fact_sequencer #(.ADDR_W(4), .DATA_W(16), .CNT_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .counter_load (counter_load),
    .counter_dec  (counter_dec),
    .acc_init     (acc_init),
    .acc_mul      (acc_mul),
    .counter_val  (counter_val),
    .mul_ovf      (mul_ovf),
    .state_out    (state_out)
  );

  always #5 clock = ~clock;

  // RAM, down-counter and accumulator the sequencer drives.
  logic [15:0] mem [16];
  logic [3:0]  cnt;
  logic [15:0] acc;
  logic [31:0] prod;
  logic        bd_we = 1'b0;
  logic [3:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;

  assign mem_rdata   = mem[mem_addr];
  assign counter_val = cnt;
  assign prod        = {16'd0, acc} * {28'd0, cnt};
  assign mul_ovf     = prod > 32'h0000_FFFF;

  always @(posedge clock) begin
    if (bd_we)       mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= acc;
    if (counter_load)     cnt <= mem_rdata[3:0];
    else if (counter_dec) cnt <= cnt - 4'd1;
    if (acc_init)     acc <= 16'd1;
    else if (acc_mul) acc <= prod[15:0];
  end

  typedef struct {
    logic        err;
    logic [15:0] res;
    logic [3:0]  dst;
    int          lat;
    int          muls;
    int          writes;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: n! in wide arithmetic; overflow is the first falling partial product > 16 bits.
  function automatic exp_t model(input logic [15:0] val, input logic [3:0] dst);
    exp_t   e;
    longint f;
    int     n;
    e.dst = dst; e.err = 1'b0; e.res = '0; e.muls = 0; e.writes = 0; e.lat = 0;
    if (val > 16'd15) begin
      e.err = 1'b1;
      e.lat = 2;
      return e;
    end
    n = int'(val);
    f = 1;
    for (int c = n; c >= 2; c--) begin
      f = f * c;
      e.muls++;
      if (f > 65535) begin
        e.err = 1'b1;
        break;
      end
    end
    if (e.err) begin
      e.lat = 2 * e.muls + 2;
    end else begin
      e.res    = 16'(f);
      e.writes = 1;
      e.lat    = (n <= 1) ? 4 : 2 * n + 2;
    end
    return e;
  endfunction

  // Monitor: accumulate per-run activity, score it when done appears.
  initial begin
    int         cyc, muls, wrs;
    logic [3:0] wa;
    exp_t       e;
    cyc = 0; muls = 0; wrs = 0; wa = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        cyc = 0; muls = 0; wrs = 0;
      end else begin
        if (busy) cyc++;
        if (acc_mul) muls++;
        if (mem_we) begin
          wrs++;
          wa = mem_addr;
        end
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("err_at_done", err, e.err);
            chk("latency", cyc, e.lat);
            chk("mul_pulses", muls, e.muls);
            chk("write_count", wrs, e.writes);
            if (e.writes != 0) begin
              chk("write_addr", wa, e.dst);
              chk("result", mem[e.dst], e.res);
            end
          end
          cyc = 0; muls = 0; wrs = 0;
        end
      end
    end
  end

  task automatic set_mem(input logic [3:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [3:0] s, input logic [3:0] d, input logic [15:0] val);
    set_mem(s, val);
    q.push_back(model(val, d));
    src_addr = s; dst_addr = d; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    logic [15:0] v;
    int          r, seen;
    repeat (3) @(negedge clock);
    chk("rst_state", state_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {done, mem_we, counter_load, counter_dec, acc_init, acc_mul}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) set_mem(4'(i), 16'h0);

    set_mem(4'd14, 16'hDEAD);
    run_op(4'd15, 4'd14, 16'd5);
    run_op(4'd3, 4'd7, 16'd0);
    run_op(4'd3, 4'd7, 16'd1);
    run_op(4'd0, 4'd2, 16'd8);
    run_op(4'd0, 4'd2, 16'd9);
    chk("err_sticky", err, 1);
    run_op(4'd4, 4'd5, 16'h0010);
    run_op(4'd11, 4'd11, 16'd6);

    // start held high: exactly two back-to-back runs with one idle cycle between
    set_mem(4'd6, 16'd5);
    q.push_back(model(16'd5, 4'd9));
    q.push_back(model(16'd5, 4'd9));
    src_addr = 4'd6; dst_addr = 4'd9; start = 1'b1;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    chk("held_done_seen", seen, 1);
    @(negedge clock);
    chk("held_gap_state", state_out, 0);
    @(negedge clock);
    chk("held_restart_state", state_out, 1);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clock);
    chk("held_no_third", busy, 0);

    // start pulse during MUL is not queued
    set_mem(4'd6, 16'd5);
    q.push_back(model(16'd5, 4'd12));
    src_addr = 4'd6; dst_addr = 4'd12; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      if (state_out == 3'd3) seen = 1;
      else @(negedge clock);
    end
    chk("mul_reached", seen, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clock);
    chk("mul_start_ignored", busy, 0);

    // reset during the third MUL aborts without writing
    set_mem(4'd8, 16'd5);
    set_mem(4'd10, 16'h1234);
    src_addr = 4'd8; dst_addr = 4'd10; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && seen < 3; i++) begin
      @(negedge clock);
      if (acc_mul) seen++;
    end
    chk("third_mul_reached", seen, 3);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_state", state_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_no_write", mem[4'd10], 16'h1234);
    run_op(4'd8, 4'd10, 16'd3);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      v = 16'($urandom_range(0, 8));
      else if (r < 8) v = 16'($urandom_range(9, 15));
      else            v = 16'($urandom_range(16, 65535));
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), v);
    end

    repeat (2) @(negedge clock);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
